// File: rtl/neopix_decoder.sv
// neopix_decoder: WS2812 (NeoPixel) bitstream receiver.
// Synchronizes din_i, times each high pulse to recover 0/1 bits, assembles
// 24-bit GRB words MSB-first and hands them out over a valid/ready pair.
// A long low gap ends a frame (latch_o). Over-long pulses, partial pixels at
// latch time and pixels dropped under back-pressure set the sticky err_o.
// Optional feature macro: NEOPIX_DECODER_FRAME_LEN_EN enables the per-frame
// pixel counter behind frame_len_o; without it frame_len_o is tied to 0.
module neopix_decoder #(
    parameter int SYSTEM_CLOCK  = 50000000,
    parameter int BIT_THRESH_NS = 600,
    parameter int LATCH_NS      = 50000,
    parameter int MAX_HIGH_NS   = 2000
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        din_i,
    output logic [23:0] pix_o,
    output logic        pix_valid_o,
    input  logic        pix_ready_i,
    output logic        latch_o,
    output logic        err_o,
    output logic [15:0] frame_len_o
);

    localparam int CLK_MHZ        = SYSTEM_CLOCK / 1000000;
    localparam int BIT_THRESH_CYC = CLK_MHZ * BIT_THRESH_NS / 1000;
    localparam int LATCH_CYC      = CLK_MHZ * LATCH_NS / 1000;
    localparam int MAX_HIGH_CYC   = CLK_MHZ * MAX_HIGH_NS / 1000;
    localparam int LOW_W          = $clog2(LATCH_CYC + 1);
    localparam int HIGH_W         = $clog2(MAX_HIGH_CYC + 1);

    localparam logic [LOW_W-1:0]  LATCH_V      = LOW_W'(LATCH_CYC);
    localparam logic [LOW_W-1:0]  LATCH_M1_V   = LOW_W'(LATCH_CYC - 1);
    localparam logic [HIGH_W-1:0] BIT_THRESH_V = HIGH_W'(BIT_THRESH_CYC);
    localparam logic [HIGH_W-1:0] MAX_HIGH_V   = HIGH_W'(MAX_HIGH_CYC);

    typedef enum logic [1:0] {SYNC, LOW, HIGH, ERROR} state_t;

    logic [1:0]        rst_sync;
    logic              rst_n;
    logic              din_s1, din_s2, din_d;
    logic              rise, fall, low_full, bit_val;
    logic              word_done, latch_evt, err_evt;
    logic [LOW_W-1:0]  low_cnt;
    logic [HIGH_W-1:0] high_cnt;
    logic [4:0]        bit_cnt;
    logic [22:0]       shreg;
    logic [23:0]       word;
    state_t            state;

    // Reset asserts immediately, releases only after two clean clock edges.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            din_s1 <= 1'b0;
            din_s2 <= 1'b0;
            din_d  <= 1'b0;
        end else begin
            din_s1 <= din_i;
            din_s2 <= din_s1;
            din_d  <= din_s2;
        end
    end

    // Edge strobes and the events shared by the FSM and the pixel counter.
    always_comb begin
        rise      = din_s2 & ~din_d;
        fall      = ~din_s2 & din_d;
        low_full  = ~din_s2 && (low_cnt == LATCH_M1_V);
        bit_val   = (high_cnt >= BIT_THRESH_V);
        word      = {shreg, bit_val};
        word_done = (state == HIGH) && fall && (bit_cnt == 5'd23);
        latch_evt = (state == LOW) && low_full;
        err_evt   = (state == HIGH) && !fall && (high_cnt == MAX_HIGH_V);
    end

    // Consecutive-low counter; saturates at LATCH so a gap fires only once,
    // and a saturated count on entry to LOW means no latch until new bits.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                low_cnt <= '0;
        else if (din_s2)           low_cnt <= '0;
        else if (low_cnt != LATCH_V) low_cnt <= low_cnt + 1'b1;
    end

    // Decoder FSM with registered outputs and the pixel handshake.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state       <= SYNC;
            high_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            pix_o       <= '0;
            pix_valid_o <= 1'b0;
            latch_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            latch_o <= latch_evt;
            if (pix_valid_o && pix_ready_i) pix_valid_o <= 1'b0;
            case (state)
                SYNC: begin
                    if (low_full) state <= LOW;
                end
                LOW: begin
                    if (latch_evt) begin
                        if (bit_cnt != 5'd0) err_o <= 1'b1;
                        bit_cnt <= '0;
                    end else if (rise) begin
                        state    <= HIGH;
                        // the rise cycle is itself the first high cycle
                        high_cnt <= HIGH_W'(1);
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state   <= LOW;
                        shreg   <= word[22:0];
                        bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                        if (word_done) begin
                            if (!pix_valid_o || pix_ready_i) begin
                                pix_o       <= word;
                                pix_valid_o <= 1'b1;
                            end else begin
                                err_o <= 1'b1;
                            end
                        end
                    end else if (err_evt) begin
                        state   <= ERROR;
                        err_o   <= 1'b1;
                        bit_cnt <= '0;
                    end else begin
                        high_cnt <= high_cnt + 1'b1;
                    end
                end
                ERROR: begin
                    if (low_full) state <= LOW;
                end
                default: state <= SYNC;
            endcase
        end
    end

`ifdef NEOPIX_DECODER_FRAME_LEN_EN
    logic [15:0] pix_cnt;

    // Counts completed words (dropped ones too); an aborted frame restarts it.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt     <= '0;
            frame_len_o <= '0;
        end else if (latch_evt) begin
            frame_len_o <= pix_cnt;
            pix_cnt     <= '0;
        end else if (err_evt) begin
            pix_cnt <= '0;
        end else if (word_done && pix_cnt != 16'hFFFF) begin
            pix_cnt <= pix_cnt + 16'd1;
        end
    end
`else
    assign frame_len_o = '0;
`endif

endmodule

// File: tb/tb_neopix_decoder.sv
// Directed bench for neopix_decoder at 50 MHz with default timing parameters.
module tb_neopix_decoder;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        din_i;
    logic [23:0] pix_o;
    logic        pix_valid_o;
    logic        pix_ready_i;
    logic        latch_o;
    logic        err_o;
    logic [15:0] frame_len_o;

    int checks = 0;
    int fails  = 0;
    int vpulses = 0;
    int latches = 0;
    logic prev_v = 1'b0;

`ifdef NEOPIX_DECODER_FRAME_LEN_EN
    localparam bit FL_EN = 1'b1;
`else
    localparam bit FL_EN = 1'b0;
`endif

    neopix_decoder dut (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .din_i       (din_i),
        .pix_o       (pix_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .latch_o     (latch_o),
        .err_o       (err_o),
        .frame_len_o (frame_len_o)
    );

    always #10 clk_i = ~clk_i;

    // Event counters sampled away from the active edge.
    always @(negedge clk_i) begin
        if (pix_valid_o && !prev_v) vpulses++;
        prev_v = pix_valid_o;
        if (latch_o) latches++;
    end

    task automatic send_bit(input int hi, input int lo);
        @(posedge clk_i); #1 din_i = 1'b1;
        repeat (hi) @(posedge clk_i);
        #1 din_i = 1'b0;
        repeat (lo - 1) @(posedge clk_i);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) begin
            if (w[i]) send_bit(40, 23);
            else      send_bit(20, 43);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        #3 reset_ni = 1'b0;
        din_i = 1'b0;
        idle(3);
        reset_ni = 1'b1;
        idle(3000);
    endtask

    task automatic test_reset();
        reset_ni = 1'b0; din_i = 1'b0; pix_ready_i = 1'b1;
        idle(4);
        checks++; if (pix_o !== 24'h0) begin fails++; $display("FAIL reset_pix got %h exp 000000", pix_o); end
        checks++; if (pix_valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", pix_valid_o); end
        checks++; if (latch_o !== 1'b0) begin fails++; $display("FAIL reset_latch got %b exp 0", latch_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset_err got %b exp 0", err_o); end
        checks++; if (frame_len_o !== 16'h0) begin fails++; $display("FAIL reset_flen got %0d exp 0", frame_len_o); end
        reset_ni = 1'b1;
        idle(3000);
    endtask

    task automatic test_basic();
        int v0, l0;
        logic [23:0] w;
        v0 = vpulses; l0 = latches; w = 24'hFF0055;
        pix_ready_i = 1'b1;
        for (int i = 23; i >= 1; i--) begin
            if (w[i]) send_bit(40, 23);
            else      send_bit(20, 43);
        end
        // last bit (a 1): watch the latency from its falling edge
        @(posedge clk_i); #1 din_i = 1'b1;
        repeat (40) @(posedge clk_i);
        #1 din_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        checks++; if (pix_valid_o !== 1'b1) begin fails++; $display("FAIL basic_latency valid got %b exp 1", pix_valid_o); end
        checks++; if (pix_o !== 24'hFF0055) begin fails++; $display("FAIL basic_pix got %h exp ff0055", pix_o); end
        idle(1);
        checks++; if (pix_valid_o !== 1'b0) begin fails++; $display("FAIL basic_consume valid got %b exp 0", pix_valid_o); end
        idle(3000);
        checks++; if (vpulses - v0 !== 1) begin fails++; $display("FAIL basic_vpulses got %0d exp 1", vpulses - v0); end
        checks++; if (latches - l0 !== 1) begin fails++; $display("FAIL basic_latches got %0d exp 1", latches - l0); end
        checks++; if (frame_len_o !== (FL_EN ? 16'd1 : 16'd0)) begin fails++; $display("FAIL basic_flen got %0d exp %0d", frame_len_o, FL_EN ? 1 : 0); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL basic_err got %b exp 0", err_o); end
    endtask

    task automatic test_thresh();
        // 21 zeros, then 100 high (max legal, 1), 29 high (0), 30 high (1)
        for (int i = 0; i < 21; i++) send_bit(20, 43);
        send_bit(100, 40);
        send_bit(29, 34);
        send_bit(30, 33);
        idle(3000);
        checks++; if (pix_o !== 24'h000005) begin fails++; $display("FAIL thresh_pix got %h exp 000005", pix_o); end
        checks++; if (err_o !== 1'b0) begin fails++; $display("FAIL thresh_err got %b exp 0", err_o); end
    endtask

    task automatic test_drop();
        int v0;
        v0 = vpulses;
        pix_ready_i = 1'b0;
        send_word(24'h000001);
        send_word(24'h800000);
        idle(5);
        checks++; if (pix_o !== 24'h000001) begin fails++; $display("FAIL drop_pix got %h exp 000001", pix_o); end
        checks++; if (pix_valid_o !== 1'b1) begin fails++; $display("FAIL drop_valid got %b exp 1", pix_valid_o); end
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL drop_err got %b exp 1", err_o); end
        idle(3000);
        checks++; if (frame_len_o !== (FL_EN ? 16'd2 : 16'd0)) begin fails++; $display("FAIL drop_flen got %0d exp %0d", frame_len_o, FL_EN ? 2 : 0); end
        checks++; if (vpulses - v0 !== 1) begin fails++; $display("FAIL drop_vpulses got %0d exp 1", vpulses - v0); end
        pix_ready_i = 1'b1;
        idle(2);
        checks++; if (pix_valid_o !== 1'b0) begin fails++; $display("FAIL drop_drain valid got %b exp 0", pix_valid_o); end
    endtask

    task automatic test_partial();
        int v0, l0;
        do_reset();
        pix_ready_i = 1'b1;
        v0 = vpulses; l0 = latches;
        for (int i = 0; i < 10; i++) send_bit(40, 23);
        idle(3000);
        checks++; if (vpulses - v0 !== 0) begin fails++; $display("FAIL partial_vpulses got %0d exp 0", vpulses - v0); end
        checks++; if (latches - l0 !== 1) begin fails++; $display("FAIL partial_latches got %0d exp 1", latches - l0); end
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL partial_err got %b exp 1", err_o); end
        send_word(24'h123456);
        idle(3000);
        checks++; if (pix_o !== 24'h123456) begin fails++; $display("FAIL partial_next_pix got %h exp 123456", pix_o); end
        checks++; if (latches - l0 !== 2) begin fails++; $display("FAIL partial_next_latches got %0d exp 2", latches - l0); end
    endtask

    task automatic test_long_high();
        int l0;
        do_reset();
        pix_ready_i = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(20, 43);
        l0 = latches;
        send_bit(150, 40);
        checks++; if (err_o !== 1'b1) begin fails++; $display("FAIL longhigh_err got %b exp 1", err_o); end
        idle(3000);
        checks++; if (latches - l0 !== 0) begin fails++; $display("FAIL longhigh_nolatch got %0d exp 0", latches - l0); end
        send_word(24'hA5A5A5);
        idle(3000);
        checks++; if (pix_o !== 24'hA5A5A5) begin fails++; $display("FAIL longhigh_next_pix got %h exp a5a5a5", pix_o); end
        checks++; if (latches - l0 !== 1) begin fails++; $display("FAIL longhigh_next_latch got %0d exp 1", latches - l0); end
        checks++; if (frame_len_o !== (FL_EN ? 16'd1 : 16'd0)) begin fails++; $display("FAIL longhigh_flen got %0d exp %0d", frame_len_o, FL_EN ? 1 : 0); end
    endtask

    task automatic test_reset_mid();
        int v0, l0;
        do_reset();
        pix_ready_i = 1'b0;
        send_word(24'h0F0F0F);
        idle(5);
        checks++; if (pix_valid_o !== 1'b1) begin fails++; $display("FAIL rstmid_pre_valid got %b exp 1", pix_valid_o); end
        for (int i = 0; i < 12; i++) send_bit(40, 23);
        #5 reset_ni = 1'b0;
        #1;
        checks++; if (pix_o !== 24'h0) begin fails++; $display("FAIL rstmid_pix got %h exp 000000", pix_o); end
        checks++; if (pix_valid_o !== 1'b0) begin fails++; $display("FAIL rstmid_valid got %b exp 0", pix_valid_o); end
        checks++; if (err_o !== 1'b0 || latch_o !== 1'b0 || frame_len_o !== 16'h0) begin
            fails++; $display("FAIL rstmid_misc err %b latch %b flen %0d exp 0 0 0", err_o, latch_o, frame_len_o);
        end
        idle(2);
        reset_ni = 1'b1;
        pix_ready_i = 1'b1;
        v0 = vpulses; l0 = latches;
        send_word(24'h654321);
        idle(3000);
        checks++; if (vpulses - v0 !== 0) begin fails++; $display("FAIL rstmid_sync_vpulses got %0d exp 0", vpulses - v0); end
        checks++; if (pix_o !== 24'h0) begin fails++; $display("FAIL rstmid_sync_pix got %h exp 000000", pix_o); end
        checks++; if (latches - l0 !== 0) begin fails++; $display("FAIL rstmid_sync_latch got %0d exp 0", latches - l0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_thresh();
        test_drop();
        test_partial();
        test_long_high();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
